// File: rtl/blake2b_msg_sched_pkg.sv
// ============================================================================
// Module   : blake2b_msg_sched_pkg
// Brief    : Shared sizes, types and the sigma permutation table for the
//            BLAKE2b message-word scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package blake2b_msg_sched_pkg;

    localparam int c_ROUND_NUM       = 12;
    localparam int c_G_NUM           = 8;
    localparam int c_WORD_W          = 64;
    localparam int c_BLOCK_W         = 1024;
    localparam int c_ROUND_W         = 4;
    localparam int c_GINDEX_W        = 3;
    localparam int c_SIGMA_INDEX_W   = 4;
    localparam int c_MINDEX_W        = 4;

    typedef logic [c_WORD_W-1:0]        word_t;
    typedef logic [c_BLOCK_W-1:0]       block_t;
    typedef logic [c_ROUND_W-1:0]       round_t;
    typedef logic [c_GINDEX_W-1:0]      gindex_t;
    typedef logic [c_SIGMA_INDEX_W-1:0] sigma_idx_t;
    typedef logic [c_MINDEX_W-1:0]      mindex_t;

    localparam round_t  c_LAST_ROUND = round_t'(c_ROUND_NUM - 1);
    localparam gindex_t c_LAST_G     = gindex_t'(c_G_NUM - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One row per round; nibble k holds sigma[row][k]. Rows 10/11 repeat
    // rows 0/1, rows 12..15 are never addressed.
    localparam logic [63:0] c_SIGMA_TABLE [16] = '{
        64'hFEDCBA9876543210,
        64'h357B20C16DF984AE,
        64'h491763EADF250C8B,
        64'h8F04A562EBCD1397,
        64'hD386CB1EFA427509,
        64'h91EF57D438B0A6C2,
        64'hB8293670A4DEF15C,
        64'hA2684F05931CE7BD,
        64'h5A417D2C803B9EF6,
        64'h0DC3E9BF5167482A,
        64'hFEDCBA9876543210,
        64'h357B20C16DF984AE,
        64'h0000000000000000,
        64'h0000000000000000,
        64'h0000000000000000,
        64'h0000000000000000
    };

endpackage

`default_nettype wire

// File: rtl/blake2b_sigma.sv
// ============================================================================
// Module   : blake2b_sigma
// Brief    : Combinational BLAKE2b sigma lookup: (round row, column) to
//            message word index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module blake2b_sigma
    import blake2b_msg_sched_pkg::*;
(
    input  logic [c_ROUND_W-1:0]       row_i,
    input  logic [c_SIGMA_INDEX_W-1:0] col_i,
    output logic [c_MINDEX_W-1:0]      m_index_o
);

    logic [63:0] w_row;

    assign w_row     = c_SIGMA_TABLE[row_i];
    assign m_index_o = w_row[{col_i, 2'b00} +: c_MINDEX_W];

endmodule

`default_nettype wire

// File: rtl/blake2b_msg_sched.sv
// ============================================================================
// Module   : blake2b_msg_sched
// Brief    : Captures one 128-byte block and streams the sigma-permuted word
//            pair for each of the 96 G invocations over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module blake2b_msg_sched
    import blake2b_msg_sched_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   msg_valid_i,
    output logic                   msg_ready_o,
    input  logic [c_BLOCK_W-1:0]   msg_block_i,
    output logic                   word_valid_o,
    input  logic                   word_ready_i,
    output logic [c_WORD_W-1:0]    m_x_o,
    output logic [c_WORD_W-1:0]    m_y_o,
    output logic [c_ROUND_W-1:0]   round_o,
    output logic [c_GINDEX_W-1:0]  g_index_o,
    output logic                   last_o,
    output logic                   busy_o
);

    state_t  r_state;
    state_t  w_state_next;
    block_t  r_msg;
    block_t  w_src_block;
    round_t  r_round;
    round_t  w_next_round;
    gindex_t r_g;
    gindex_t w_next_g;
    word_t   r_m_x;
    word_t   r_m_y;
    word_t   w_word_x;
    word_t   w_word_y;
    mindex_t w_idx_x;
    mindex_t w_idx_y;
    logic    r_last;
    logic    w_accept;
    logic    w_advance;
    logic    w_load;
    logic    w_next_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        w_next_round = r_round;
        w_next_g     = r_g;
        case (r_state)
            ST_IDLE: begin
                if (msg_valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                    w_next_round = '0;
                    w_next_g     = '0;
                end
            end
            ST_RUN: begin
                if (word_ready_i) begin
                    if (r_last) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_advance = 1'b1;
                        if (r_g == c_LAST_G) begin
                            w_next_g     = '0;
                            w_next_round = r_round + round_t'(1);
                        end else begin
                            w_next_g = r_g + gindex_t'(1);
                        end
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_load      = w_accept | w_advance;
    assign w_next_last = (w_next_round == c_LAST_ROUND) && (w_next_g == c_LAST_G);

    // On the load edge the words are not yet registered, so index the input bus.
    assign w_src_block = w_accept ? msg_block_i : r_msg;

    blake2b_sigma u_sigma_x (
        .row_i     (w_next_round),
        .col_i     ({w_next_g, 1'b0}),
        .m_index_o (w_idx_x)
    );

    blake2b_sigma u_sigma_y (
        .row_i     (w_next_round),
        .col_i     ({w_next_g, 1'b1}),
        .m_index_o (w_idx_y)
    );

    assign w_word_x = w_src_block[{w_idx_x, 6'd0} +: c_WORD_W];
    assign w_word_y = w_src_block[{w_idx_y, 6'd0} +: c_WORD_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_msg   <= '0;
            r_round <= '0;
            r_g     <= '0;
            r_m_x   <= '0;
            r_m_y   <= '0;
            r_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_msg <= msg_block_i;
            end
            if (w_load) begin
                r_round <= w_next_round;
                r_g     <= w_next_g;
                r_m_x   <= w_word_x;
                r_m_y   <= w_word_y;
                r_last  <= w_next_last;
            end else if (w_state_next == ST_IDLE) begin
                r_last <= 1'b0;
            end
        end
    end

    assign msg_ready_o  = (r_state == ST_IDLE);
    assign busy_o       = (r_state == ST_RUN);
    assign word_valid_o = (r_state == ST_RUN);
    assign m_x_o        = r_m_x;
    assign m_y_o        = r_m_y;
    assign round_o      = r_round;
    assign g_index_o    = r_g;
    assign last_o       = r_last;

endmodule

`default_nettype wire
